i2c_target_model: RTL and testbench

- Parametrised virtual I2C target (register-file/EEPROM style) for the Verilator top level; it sits on an open-drain bus next to a sonata_system I2C host.
- Replaces the "nothing driving the bus" arrangement. It answers to a 7-bit address, exposes a byte memory through an auto-incrementing pointer, and can optionally stretch SCL.
- Each simulated bus gets its own instance; the top level resolves open-drain wiring: line = 0 if any driver enabled, else 1.

---
 rtl/i2c_target_model.sv | 191 +++++++++++++++++++
 tb/tb_i2c_target_model.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_model.sv
// Virtual I2C target: byte memory behind an auto-incrementing pointer, open-drain
// SCL/SDA enables, optional SCL stretching after every acknowledged byte.
module i2c_target_model #(
  parameter logic [6:0] TargetAddr    = 7'h50,
  parameter int         MemDepth      = 256,
  parameter logic [7:0] MemInit       = 8'h00,
  parameter int         StretchCycles = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic [7:0] bd_addr_i,
  output logic [7:0] bd_rdata_o,
  output logic       busy_o,
  output logic       nack_o
);

  localparam int AW = $clog2(MemDepth);
  localparam int SW = (StretchCycles > 1) ? $clog2(StretchCycles) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, RDATA, IGNORE
  } state_e;

  state_e          state;
  logic [1:0]      scl_sync, sda_sync;
  logic            scl_q, sda_q;
  logic            scl_s, sda_s;
  logic            scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;
  logic [7:0]      mem_at_ptr;
  logic            rw;
  logic [AW-1:0]   ptr;
  logic [SW-1:0]   str_cnt;
  logic [7:0]      mem [MemDepth];
  logic            bd_unused;

  // Two-flop synchronisers plus one history stage for edge detection; idle bus is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign rx_byte    = {shreg[6:0], sda_s};
  assign mem_at_ptr = mem[ptr];
  assign bd_rdata_o = mem[bd_addr_i[AW-1:0]];
  assign bd_unused  = ^bd_addr_i;

  // bit_cnt counts SCL rises within a byte: 0..7 data, 8 = ninth-bit window, 9 = after bit 9 rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      sda_oe_o <= 1'b0;
      scl_oe_o <= 1'b0;
      str_cnt  <= '0;
      busy_o   <= 1'b0;
      nack_o   <= 1'b0;
      for (int i = 0; i < MemDepth; i++) mem[i] <= MemInit;
    end else begin
      nack_o <= 1'b0;
      if (scl_oe_o) begin
        if (str_cnt == '0) scl_oe_o <= 1'b0;
        else               str_cnt  <= str_cnt - 1'b1;
      end

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe_o <= 1'b0;
        scl_oe_o <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        busy_o   <= 1'b0;
        sda_oe_o <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, ADDR_ACK, PTR, WDATA: begin
            if (bit_cnt < 4'd8) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                case (state)
                  ADDR: begin
                    if (rx_byte[7:1] == TargetAddr) begin
                      state  <= ADDR_ACK;
                      busy_o <= 1'b1;
                      rw     <= rx_byte[0];
                    end else begin
                      state  <= IGNORE;
                    end
                  end
                  PTR:   ptr <= rx_byte[AW-1:0];
                  WDATA: begin
                    mem[ptr] <= rx_byte;
                    ptr      <= ptr + 1'b1;
                  end
                  default: ;
                endcase
              end
            end else if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd9;
            end
          end
          RDATA: begin
            if (bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd8) begin
              if (!sda_s) begin
                ptr     <= ptr + 1'b1;
                bit_cnt <= 4'd9;
              end else begin
                nack_o  <= 1'b1;
                state   <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR, WDATA: begin
            if (bit_cnt == 4'd8) begin
              sda_oe_o <= 1'b1;
            end else if (bit_cnt == 4'd9) begin
              bit_cnt  <= '0;
              sda_oe_o <= 1'b0;
              if (StretchCycles > 0) begin
                scl_oe_o <= 1'b1;
                str_cnt  <= SW'(StretchCycles - 1);
              end
              if (state == ADDR_ACK && rw) begin
                state    <= RDATA;
                shreg    <= mem_at_ptr;
                sda_oe_o <= ~mem_at_ptr[7];
              end else if (state == ADDR_ACK) begin
                state    <= PTR;
              end else begin
                state    <= WDATA;
              end
            end
          end
          RDATA: begin
            if (bit_cnt == 4'd9) begin
              bit_cnt  <= '0;
              shreg    <= mem_at_ptr;
              sda_oe_o <= ~mem_at_ptr[7];
              if (StretchCycles > 0) begin
                scl_oe_o <= 1'b1;
                str_cnt  <= SW'(StretchCycles - 1);
              end
            end else if (bit_cnt == 4'd8) begin
              sda_oe_o <= 1'b0;
            end else if (bit_cnt != 4'd0) begin
              // shreg[6] is the next bit once the previous one has been shifted out
              sda_oe_o <= ~shreg[6];
              shreg    <= {shreg[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench: bit-banged I2C host on two buses (stretching 256-byte target, plain 16-byte target),
// expectations queued at stimulus time and compared by a separate monitor.
module tb_i2c_target_model;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_scl_low = 1'b0;
  logic       host_sda_low = 1'b0;
  int         sel = 0;
  logic       scl0, sda0, scl1, sda1, scl_r, sda_r;
  logic       scl_oe0, sda_oe0, busy0, nack0;
  logic       scl_oe1, sda_oe1, busy1, nack1;
  logic [7:0] bd_addr0 = 8'h00, bd_addr1 = 8'h00;
  logic [7:0] bd_rdata0, bd_rdata1;

  always #5 clk = ~clk;

  assign scl0  = ~((host_scl_low && sel == 0) || scl_oe0);
  assign sda0  = ~((host_sda_low && sel == 0) || sda_oe0);
  assign scl1  = ~((host_scl_low && sel == 1) || scl_oe1);
  assign sda1  = ~((host_sda_low && sel == 1) || sda_oe1);
  assign scl_r = (sel == 1) ? scl1 : scl0;
  assign sda_r = (sel == 1) ? sda1 : sda0;

  i2c_target_model #(.TargetAddr(7'h50), .MemDepth(256), .MemInit(8'h5A), .StretchCycles(20)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl0), .sda_i(sda0),
    .scl_oe_o(scl_oe0), .sda_oe_o(sda_oe0), .bd_addr_i(bd_addr0), .bd_rdata_o(bd_rdata0),
    .busy_o(busy0), .nack_o(nack0));

  i2c_target_model #(.TargetAddr(7'h50), .MemDepth(16), .MemInit(8'h00), .StretchCycles(0)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl1), .sda_i(sda1),
    .scl_oe_o(scl_oe1), .sda_oe_o(sda_oe1), .bd_addr_i(bd_addr1), .bd_rdata_o(bd_rdata1),
    .busy_o(busy1), .nack_o(nack1));

  // scoreboard
  string       exp_name_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    expect_val(n, exp);
    observe(act);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        logic [31:0] a, e;
        string n;
        a = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0h with nothing expected", a);
        end else begin
          e = exp_q.pop_front();
          n = exp_name_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, a, e);
          end
        end
      end
    end
  end

  // side monitors: stretch run lengths, NACK pulses, activity during mismatch
  int   run = 0;
  int   runs_q[$];
  int   nack_cnt0 = 0, nack_cnt1 = 0;
  logic watch = 1'b0, sda_seen = 1'b0, busy_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) run = 0;
      else if (scl_oe0) run++;
      else if (run > 0) begin
        runs_q.push_back(run);
        run = 0;
      end
      if (nack0) nack_cnt0++;
      if (nack1) nack_cnt1++;
      if (watch) begin
        if (sda_oe0) sda_seen = 1'b1;
        if (busy0)   busy_seen = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int t;
    host_scl_low = 1'b0;
    t = 0;
    while (!scl_r && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("scl_release_timeout", 32'(scl_r), 1);
  endtask

  task automatic bit_cycle(input logic drive, output logic samp);
    host_sda_low = ~drive;
    cyc(2);
    scl_up();
    cyc(HALF / 2);
    samp = sda_r;
    cyc(HALF / 2);
    host_scl_low = 1'b1;
    cyc(HALF);
  endtask

  task automatic i2c_start();
    host_sda_low = 1'b0;
    cyc(2);
    scl_up();
    cyc(HALF);
    host_sda_low = 1'b1;
    cyc(HALF);
    host_scl_low = 1'b1;
    cyc(HALF);
  endtask

  task automatic i2c_stop();
    host_sda_low = 1'b1;
    cyc(2);
    scl_up();
    cyc(HALF);
    host_sda_low = 1'b0;
    cyc(HALF);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic s;
    expect_val("ack_bit", 32'(exp_ack));
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, s);
    observe(32'(s));
  endtask

  task automatic read_byte(input logic host_ack, input logic [7:0] exp_d);
    logic s;
    logic [7:0] d;
    expect_val("read_data", 32'(exp_d));
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(~host_ack, s);
    observe(32'(d));
  endtask

  task automatic check_bd0(input logic [7:0] a, input logic [7:0] exp);
    bd_addr0 = a;
    cyc(1);
    check("bd_rdata0", 32'(bd_rdata0), 32'(exp));
  endtask

  task automatic check_runs(input int n);
    check("stretch_count", runs_q.size(), n);
    foreach (runs_q[i]) check("stretch_len", runs_q[i], 20);
    runs_q.delete();
  endtask

  initial begin
    int nb;
    // reset state
    cyc(5);
    check("rst_sda_oe", 32'(sda_oe0), 0);
    check("rst_scl_oe", 32'(scl_oe0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_nack", 32'(nack0), 0);
    check_bd0(8'h00, 8'h5A);
    rst_n = 1'b1;
    cyc(5);

    // write then read back via backdoor
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h10, 1'b0);
    write_byte(8'hDE, 1'b0);
    write_byte(8'hAD, 1'b0);
    i2c_stop();
    cyc(5);
    check_bd0(8'h10, 8'hDE);
    check_bd0(8'h11, 8'hAD);
    check_runs(4);

    // random read with repeated START
    nb = nack_cnt0;
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h10, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0);
    read_byte(1'b1, 8'hDE);
    read_byte(1'b0, 8'hAD);
    check("busy_before_stop", 32'(busy0), 1);
    i2c_stop();
    cyc(5);
    check("nack_pulses", nack_cnt0 - nb, 1);
    check("busy_after_stop", 32'(busy0), 0);
    check_runs(4);

    // address mismatch
    sda_seen = 1'b0;
    busy_seen = 1'b0;
    watch = 1'b1;
    i2c_start();
    write_byte(8'hA2, 1'b1);
    write_byte(8'h55, 1'b1);
    i2c_stop();
    cyc(5);
    watch = 1'b0;
    check("mismatch_sda_oe", 32'(sda_seen), 0);
    check("mismatch_busy", 32'(busy_seen), 0);
    check_bd0(8'h55, 8'h5A);
    check_runs(0);

    // pointer wrap on the 16-byte target
    sel = 1;
    cyc(5);
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h0F, 1'b0);
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    i2c_stop();
    cyc(5);
    bd_addr1 = 8'h0F;
    cyc(1);
    check("wrap_mem15", 32'(bd_rdata1), 32'h11);
    bd_addr1 = 8'h00;
    cyc(1);
    check("wrap_mem0", 32'(bd_rdata1), 32'h22);
    check("wrap_busy", 32'(busy1), 0);
    check("wrap_nacks", nack_cnt1, 0);
    sel = 0;
    cyc(5);

    // aborted byte: STOP after 4 data bits
    begin
      logic s;
      i2c_start();
      write_byte(8'hA0, 1'b0);
      write_byte(8'h20, 1'b0);
      for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
      i2c_stop();
      cyc(5);
    end
    check_bd0(8'h20, 8'h5A);
    i2c_start();
    write_byte(8'hA0, 1'b0);
    i2c_stop();
    cyc(5);
    check_runs(3);

    // stretch: one write byte, then reset inside a stretch window
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h30, 1'b0);
    write_byte(8'h77, 1'b0);
    i2c_stop();
    cyc(5);
    check_bd0(8'h30, 8'h77);
    check_runs(3);
    i2c_start();
    write_byte(8'hA0, 1'b0);
    begin
      int t;
      t = 0;
      while (!scl_oe0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("stretch_started", 32'(scl_oe0), 1);
    end
    cyc(5);
    rst_n = 1'b0;
    #1;
    check("rst_async_scl_oe", 32'(scl_oe0), 0);
    check("rst_async_busy", 32'(busy0), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    i2c_stop();
    cyc(5);
    check_bd0(8'h30, 8'h5A);
    check("post_rst_sda_oe", 32'(sda_oe0), 0);
    check_runs(0);

    // drain scoreboard
    cyc(5);
    while (exp_q.size() > 0) begin
      string n;
      n = exp_name_q.pop_front();
      void'(exp_q.pop_front());
      checks++;
      errors++;
      $display("FAIL %s: no output observed, required one", n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
